// File: rtl/aemb2_gprf_wrsched.sv
// Write-port scheduler for the 64-entry dual-set register file. It clears the file after reset,
// then shares the single write port between pipeline writeback and a small late-load queue.
module aemb2_gprf_wrsched #(
    parameter int QDEPTH = 2,
    parameter int STARVE = 4
) (
    input  logic        gclk,
    input  logic        grst,
    input  logic        pip_vld,
    input  logic        pip_tid,
    input  logic [4:0]  pip_rd,
    input  logic [31:0] pip_dat,
    input  logic        ldq_vld,
    output logic        ldq_rdy,
    input  logic        ldq_tid,
    input  logic [4:0]  ldq_rd,
    input  logic [31:0] ldq_dat,
    input  logic [5:0]  hz_adr,
    output logic        hz_hit,
    output logic        wr_en,
    output logic [5:0]  wr_adr,
    output logic [31:0] wr_dat,
    output logic        stall,
    output logic        clr_busy
);

    localparam int PW   = $clog2(QDEPTH);
    localparam int OCCW = PW + 1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [6:0]        clr_cnt_q, clr_cnt_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [OCCW-1:0]   occ_q, occ_d;
    logic [3:0]        starve_q, starve_d;
    logic [QDEPTH-1:0] live_q, live_d;
    logic              wr_en_q, wr_en_d;
    logic [5:0]        wr_adr_q, wr_adr_d;
    logic [31:0]       wr_dat_q, wr_dat_d;

    // Queue payload; only the live bits need clearing on reset.
    logic [5:0]  ent_adr_q [QDEPTH];
    logic [31:0] ent_dat_q [QDEPTH];

    logic [5:0]        pip_adr;
    logic [5:0]        ldq_adr;
    logic              pip_wr;
    logic              q_pop;
    logic              q_push;
    logic [QDEPTH-1:0] kill_vec;
    logic [QDEPTH-1:0] hit_vec;

    assign pip_adr = {pip_tid, pip_rd};
    assign ldq_adr = {ldq_tid, ldq_rd};

    assign ldq_rdy  = (state_q == ST_RUN) && (occ_q < OCCW'(QDEPTH));
    assign pip_wr   = (state_q == ST_RUN) && pip_vld && (pip_rd != 5'd0);
    assign q_pop    = (state_q == ST_RUN) && !pip_wr && (occ_q != '0);
    // R0 loads complete the handshake but never occupy a slot.
    assign q_push   = ldq_vld && ldq_rdy && (ldq_rd != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_ent
            assign kill_vec[gi] = pip_wr && live_q[gi] && (ent_adr_q[gi] == pip_adr);
            assign hit_vec[gi]  = live_q[gi] && (ent_adr_q[gi] == hz_adr);
        end
    endgenerate

    assign hz_hit   = (state_q == ST_RUN) && (|hit_vec);
    assign stall    = (state_q == ST_CLEAR) || (starve_q >= 4'(STARVE));
    assign clr_busy = (state_q == ST_CLEAR);
    assign wr_en    = wr_en_q;
    assign wr_adr   = wr_adr_q;
    assign wr_dat   = wr_dat_q;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rptr_d    = rptr_q;
        wptr_d    = wptr_q;
        occ_d     = occ_q;
        starve_d  = starve_q;
        live_d    = live_q;
        wr_en_d   = 1'b0;
        wr_adr_d  = wr_adr_q;
        wr_dat_d  = wr_dat_q;

        if (state_q == ST_CLEAR) begin
            // Counter bit 6 marks the cycle after address 63 was presented.
            if (!clr_cnt_q[6]) begin
                wr_en_d   = 1'b1;
                wr_adr_d  = clr_cnt_q[5:0];
                wr_dat_d  = '0;
                clr_cnt_d = clr_cnt_q + 7'd1;
            end else begin
                state_d = ST_RUN;
            end
        end else begin
            live_d = live_q & ~kill_vec;

            if (pip_wr) begin
                wr_en_d  = 1'b1;
                wr_adr_d = pip_adr;
                wr_dat_d = pip_dat;
            end else if (q_pop) begin
                // A killed head still uses up this slot, just without a strobe.
                wr_en_d        = live_q[rptr_q];
                wr_adr_d       = ent_adr_q[rptr_q];
                wr_dat_d       = ent_dat_q[rptr_q];
                live_d[rptr_q] = 1'b0;
                rptr_d         = rptr_q + PW'(1);
            end

            if (q_push) begin
                live_d[wptr_q] = 1'b1;
                wptr_d         = wptr_q + PW'(1);
            end

            case ({q_push, q_pop})
                2'b10:   occ_d = occ_q + OCCW'(1);
                2'b01:   occ_d = occ_q - OCCW'(1);
                default: occ_d = occ_q;
            endcase

            if ((occ_q == '0) || q_pop) begin
                starve_d = 4'd0;
            end else if (starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (!grst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            rptr_q    <= '0;
            wptr_q    <= '0;
            occ_q     <= '0;
            starve_q  <= '0;
            live_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_adr_q  <= '0;
            wr_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rptr_q    <= rptr_d;
            wptr_q    <= wptr_d;
            occ_q     <= occ_d;
            starve_q  <= starve_d;
            live_q    <= live_d;
            wr_en_q   <= wr_en_d;
            wr_adr_q  <= wr_adr_d;
            wr_dat_q  <= wr_dat_d;
        end
    end

    always_ff @(posedge gclk) begin
        if (q_push) begin
            ent_adr_q[wptr_q] <= ldq_adr;
            ent_dat_q[wptr_q] <= ldq_dat;
        end
    end

endmodule

// File: doc/aemb2_gprf_wrsched.md
Name: aemb2_gprf_wrsched

Overview:
- Write-port scheduler for the dual-set (64-entry) general purpose register file.
- Clears all 64 entries to zero after reset.
- Each cycle, arbitrates the single register-file write port between in-order pipeline writeback and late-returning data-bus load results held in a small pending queue.
- Supplies an issue-side hazard lookup, and requests a pipeline hold when queued loads starve.

Parameters:
QDEPTH, 2, pending load queue depth in entries; power of two, 2..8.
STARVE, 4, cycles the queue head may wait before stall is asserted; 1..15.

Ports:
gclk  in  1  system clock, all state on rising edge
grst  in  1  synchronous reset, active-low
pip_vld  in  1  pipeline writeback valid this cycle
pip_tid  in  1  pipeline writeback thread/register set (gpha)
pip_rd  in  5  pipeline writeback destination register
pip_dat  in  32  pipeline writeback data
ldq_vld  in  1  late load result offered
ldq_rdy  out  1  queue can accept a load result this cycle
ldq_tid  in  1  load result register set
ldq_rd  in  5  load result destination register
ldq_dat  in  32  load result data
hz_adr  in  6  issue-side lookup address {tid, rd}
hz_hit  out  1  a live queued entry targets hz_adr
wr_en  out  1  register file write strobe
wr_adr  out  6  register file write address {set, reg}
wr_dat  out  32  register file write data
stall  out  1  pipeline hold request
clr_busy  out  1  reset clear sequence in progress

Behaviour:
- Reset (grst=0 at a clock edge), from any state, mid-clear included:
  - state := CLEAR, clear counter := 0, queue emptied, starve counter := 0.
  - Outputs after that edge: wr_en=0, wr_adr=0, wr_dat=0, stall=1, clr_busy=1, ldq_rdy=0, hz_hit=0.
- CLEAR state:
  - Issues wr_en=1, wr_adr=counter, wr_dat=0 for counter 0..63: one write per cycle, 64 consecutive cycles.
  - pip_vld and ldq_vld are ignored; stall=1 and ldq_rdy=0 throughout.
  - After the write of address 63, moves to RUN; clr_busy and stall fall on that same edge.
- RUN state: write port outputs are registered, one cycle latency from the accepting edge. Per-cycle priority:
  1. pip_vld=1 with pip_rd!=0: write {pip_tid,pip_rd}, pip_dat.
  2. Otherwise, if the queue is non-empty: pop the head and write it.
  3. Otherwise: wr_en=0.
- R0 is never written in RUN:
  - pip_vld with pip_rd=0 is dropped and does not consume the port, so the queue may drain that cycle.
  - ldq_vld with ldq_rd=0 is accepted (when ldq_rdy=1) and discarded without being enqueued.
- Queue handshake:
  - ldq_rdy=1 iff state=RUN and occupancy < QDEPTH.
  - A transfer occurs when ldq_vld & ldq_rdy; the entry is enqueued at the tail on that edge.
  - ldq_rdy is combinational on occupancy only, not on the same-cycle pop: a full queue stays not-ready even while popping.
- Simultaneous push and pop: both take effect; occupancy is unchanged.
- Kill rule: a pipeline write to address A in a cycle invalidates every live queued entry with address A.
  - Invalidated entries remain in the queue but are popped without a write: wr_en=0 for that pop slot, and the port is wasted for that cycle.
  - An entry pushed in the same cycle as a matching pipeline write is not killed.
- hz_hit: combinational OR over live (valid, not killed) queued entries of (entry address == hz_adr). It is 0 during CLEAR.
- Starvation:
  - The starve counter increments each cycle the queue is non-empty and no pop occurs. It resets to 0 on any pop or when the queue is empty.
  - stall=1 when counter >= STARVE.
  - While stall=1 the upstream holds pip_vld=0, so the next cycle pops; stall falls on the edge after that pop.
  - If pip_vld=1 while stall=1, the pipeline write still wins; the stall persists.
- Read/write pointers wrap modulo QDEPTH. Occupancy counter width is log2(QDEPTH)+1.

Test Plan:
- Reset hold then release: grst=0 for 3 cycles, then 1 -> exactly 64 cycles of wr_en=1, wr_adr 0..63, wr_dat=0; clr_busy/stall fall after adr 63; ldq_rdy=1 next cycle.
- Reset mid-clear: assert grst=0 at wr_adr=20 -> sequence restarts at 0, 64 full writes.
- Priority: in RUN, queue holds {0,5}=0xAAAA; pip_vld with {1,7}=0x1234 -> wr {1,7}=0x1234 next cycle; with pip_vld=0 the following cycle -> wr {0,5}=0xAAAA.
- Full queue (QDEPTH=2): push {0,3},{0,4} under continuous pip_vld -> ldq_rdy=0; stall=1 after 4 waiting cycles; drop pip_vld -> {0,3} written, stall clears.
- Kill: queue {1,9}=0x55, pipeline writes {1,9}=0x66 -> reg written 0x66 only; later pop produces wr_en=0; hz_hit for {1,9} goes 1 -> 0 at the pipeline write edge.
- R0 filter: pip_vld rd=0 and ldq rd=0 -> no write to address 0 or 32; load handshake completes; occupancy unchanged.
